// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared instruction-type definitions for the multiply/divide unit:
//   md_op encodings, default busy-cycle counts, the result record and the
//   combinational arithmetic helpers used at acceptance time.
package mult_div_unit_pkg;

  // Operation encodings on md_op; code 3'd7 is reserved and decodes as NONE.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Result held in the shadow registers until the counter expires.
  // wr is low for a divide by zero so hi/lo keep their old contents.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_result_t;

  function automatic md_op_e decode_op(input logic [2:0] code);
    md_op_e op;
    case (code)
      3'd1:    op = MD_MULT;
      3'd2:    op = MD_MULTU;
      3'd3:    op = MD_DIV;
      3'd4:    op = MD_DIVU;
      3'd5:    op = MD_MTHI;
      3'd6:    op = MD_MTLO;
      default: op = MD_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic md_result_t compute(input md_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    md_result_t         res;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] prod;
    logic        [31:0] q;
    logic        [31:0] r;
    res  = '0;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    prod = 64'd0;
    q    = 32'd0;
    r    = 32'd0;
    case (op)
      MD_MULT: begin
        prod   = sa * sb;
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MD_MULTU: begin
        prod   = {32'd0, a} * {32'd0, b};
        res.hi = prod[63:32];
        res.lo = prod[31:0];
        res.wr = 1'b1;
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          res.wr = 1'b0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // The one overflowing signed quotient wraps back to the dividend.
          res.lo = 32'h8000_0000;
          res.hi = 32'd0;
          res.wr = 1'b1;
        end else begin
          // Signed / and % truncate toward zero; remainder follows dividend sign.
          q      = $signed(a) / $signed(b);
          r      = $signed(a) % $signed(b);
          res.lo = q;
          res.hi = r;
          res.wr = 1'b1;
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          res.wr = 1'b0;
        end else begin
          res.lo = a / b;
          res.hi = a % b;
          res.wr = 1'b1;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   E-stage request bus into the multiply/divide unit and its status/result
//   outputs. master = pipeline side, slave = mult_div_unit.
//   op_valid, md_op, rs_data, rt_data : request from the pipeline
//   start (comb), busy (reg), hi, lo  : status and architectural HI/LO
interface mult_div_unit_if;
  logic        op_valid;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, md_op, rs_data, rt_data,
    input  start, busy, hi, lo
  );

  modport slave (
    input  op_valid, md_op, rs_data, rt_data,
    output start, busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_md_counter.sv
// md_counter
//   Busy down-counter of the multiply/divide unit; the only state machine
//   (IDLE when the count is zero, RUN otherwise).
//   clk, reset_n : clock, async active-low reset
//   load_i       : load load_val_i (only asserted while idle)
//   busy_o       : registered, high while the count is nonzero
//   done_o       : high in the last busy cycle (count == 1)
module md_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             busy_q;
  logic             done_s;

  // State register: count and its registered busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= (count_d != '0);
    end
  end

  // Next-state: load from idle, otherwise count down to zero and stay there.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Outputs: completion strobe on the final RUN cycle.
  always_comb begin
    done_s = (count_q == CNT_W'(1));
  end

  assign busy_o = busy_q;
  assign done_o = done_s;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   HI/LO multiply/divide unit. MULT/MULTU/DIV/DIVU results are computed
//   combinationally on acceptance, parked in shadow registers and copied into
//   hi/lo when the busy counter expires. MTHI/MTLO write hi/lo directly.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : op_valid, md_op, rs_data, rt_data in; start, busy, hi, lo out
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic             clk,
  input logic             reset_n,
  mult_div_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_op_e           op_s;
  logic             accept_s;
  logic             start_s;
  logic             busy_s;
  logic             done_s;
  logic [CNT_W-1:0] load_val_s;
  md_result_t       res_s;

  logic [31:0] shadow_hi_q;
  logic [31:0] shadow_lo_q;
  logic        shadow_wr_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Request decode and acceptance; anything presented while busy is dropped.
  always_comb begin
    op_s       = decode_op(bus.md_op);
    accept_s   = bus.op_valid & ~busy_s;
    start_s    = accept_s & is_arith(op_s);
    res_s      = compute(op_s, bus.rs_data, bus.rt_data);
    load_val_s = is_div(op_s) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  md_counter #(
    .CNT_W (CNT_W)
  ) u_md_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (start_s),
    .load_val_i (load_val_s),
    .busy_o     (busy_s),
    .done_o     (done_s)
  );

  // Shadow registers: capture the result at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_hi_q <= 32'd0;
      shadow_lo_q <= 32'd0;
      shadow_wr_q <= 1'b0;
    end else if (start_s) begin
      shadow_hi_q <= res_s.hi;
      shadow_lo_q <= res_s.lo;
      shadow_wr_q <= res_s.wr;
    end else begin
      shadow_hi_q <= shadow_hi_q;
      shadow_lo_q <= shadow_lo_q;
      shadow_wr_q <= shadow_wr_q;
    end
  end

  // HI/LO next value: completion and MTHI/MTLO are exclusive since
  // completion only happens while busy and moves only happen while idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (done_s && shadow_wr_q) begin
      hi_d = shadow_hi_q;
      lo_d = shadow_lo_q;
    end else if (accept_s && (op_s == MD_MTHI)) begin
      hi_d = bus.rs_data;
    end else if (accept_s && (op_s == MD_MTLO)) begin
      lo_d = bus.rs_data;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.start = start_s;
  assign bus.busy  = busy_s;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Table of directed vectors, hand-written sequences for ignored-while-busy
//   and mid-operation reset, then random ops against an arithmetic model.
module tb_mult_div_unit;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [31:0] mhi;
  logic [31:0] mlo;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_start;
    int          ncyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl,
                       output logic arith, output int cyc);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     t;
    logic [63:0]     u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = mhi;
    nl = mlo;
    arith = 1'b0;
    cyc = 0;
    case (op)
      3'd1: begin arith = 1'b1; cyc = 5; t = sa * sb; nh = t[63:32]; nl = t[31:0]; end
      3'd2: begin arith = 1'b1; cyc = 5; t = ua * ub; nh = t[63:32]; nl = t[31:0]; end
      3'd3: begin
        arith = 1'b1; cyc = 10;
        if (b != 32'd0) begin t = sa / sb; u = sa % sb; nl = t[31:0]; nh = u[31:0]; end
      end
      3'd4: begin
        arith = 1'b1; cyc = 10;
        if (b != 32'd0) begin t = ua / ub; u = ua % ub; nl = t[31:0]; nh = u[31:0]; end
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge of the first non-busy cycle.
  task automatic do_op(input string tag, input logic v, input logic [2:0] op,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic exp_start, input int ncyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = mhi;
    old_lo = mlo;
    bus.op_valid = v;
    bus.md_op    = op;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    #1;
    chk({tag, ".start"}, 32'(bus.start), 32'(exp_start));
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd0;
    for (int k = 0; k < ncyc; k++) begin
      chk($sformatf("%s.busy%0d", tag, k + 1), 32'(bus.busy), 32'd1);
      chk($sformatf("%s.hold_hi%0d", tag, k + 1), bus.hi, old_hi);
      chk($sformatf("%s.hold_lo%0d", tag, k + 1), bus.lo, old_lo);
      @(negedge clk);
    end
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    chk({tag, ".hi"}, bus.hi, exp_hi);
    chk({tag, ".lo"}, bus.lo, exp_lo);
    mhi = exp_hi;
    mlo = exp_lo;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] nh;
    logic [31:0] nl;
    logic        ar;
    logic        v;
    int          cyc;

    checks = 0;
    errors = 0;
    mhi = 32'd0;
    mlo = 32'd0;

    //            v     op    rs             rt             start ncyc exp_hi         exp_lo
    tbl[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3,         1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2]  = '{1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2,         1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{1'b1, 3'd5, 32'h0000_1234, 32'd0,         1'b0, 0,  32'h0000_1234, 32'hFFFF_FFFD};
    tbl[4]  = '{1'b1, 3'd6, 32'h0000_5678, 32'd0,         1'b0, 0,  32'h0000_1234, 32'h0000_5678};
    tbl[5]  = '{1'b1, 3'd4, 32'd9,         32'd0,         1'b1, 10, 32'h0000_1234, 32'h0000_5678};
    tbl[6]  = '{1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h0000_0000, 32'h8000_0000};
    tbl[7]  = '{1'b1, 3'd4, 32'd100,       32'd7,         1'b1, 10, 32'd2,         32'd14};
    tbl[8]  = '{1'b1, 3'd3, 32'd7,         32'hFFFF_FFFE, 1'b1, 10, 32'd1,         32'hFFFF_FFFD};
    tbl[9]  = '{1'b1, 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 5,  32'h4000_0000, 32'h0000_0000};
    tbl[10] = '{1'b1, 3'd7, 32'h0000_9999, 32'd1,         1'b0, 0,  32'h4000_0000, 32'h0000_0000};
    tbl[11] = '{1'b0, 3'd1, 32'd2,         32'd3,         1'b0, 0,  32'h4000_0000, 32'h0000_0000};
    tbl[12] = '{1'b0, 3'd5, 32'h0000_0077, 32'd0,         1'b0, 0,  32'h4000_0000, 32'h0000_0000};
    tbl[13] = '{1'b1, 3'd1, 32'd3,         32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFD};

    reset_n      = 1'b0;
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd0;
    bus.rs_data  = 32'd0;
    bus.rt_data  = 32'd0;
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.hi", bus.hi, 32'd0);
    chk("rst.lo", bus.lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed table; consecutive arithmetic rows also exercise back-to-back starts.
    for (int i = 0; i < 14; i++) begin
      do_op($sformatf("tbl%0d", i), tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt,
            tbl[i].exp_start, tbl[i].ncyc, tbl[i].exp_hi, tbl[i].exp_lo);
    end

    // MULT followed by MTLO held valid throughout the busy window: MTLO ignored.
    bus.op_valid = 1'b1;
    bus.md_op    = 3'd1;
    bus.rs_data  = 32'd3;
    bus.rt_data  = 32'd5;
    #1;
    chk("mtlo_busy.start", 32'(bus.start), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      bus.op_valid = 1'b1;
      bus.md_op    = 3'd6;
      bus.rs_data  = 32'h0000_AAAA;
      #1;
      chk($sformatf("mtlo_busy.nostart%0d", k), 32'(bus.start), 32'd0);
      chk($sformatf("mtlo_busy.busy%0d", k), 32'(bus.busy), 32'd1);
      chk($sformatf("mtlo_busy.lo_hold%0d", k), bus.lo, 32'hFFFF_FFFD);
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd0;
    #1;
    chk("mtlo_busy.idle", 32'(bus.busy), 32'd0);
    chk("mtlo_busy.hi", bus.hi, 32'd0);
    chk("mtlo_busy.lo", bus.lo, 32'd15);
    mhi = 32'd0;
    mlo = 32'd15;
    @(negedge clk);

    // Reset pulsed during cycle T+3 of a DIV: abort, nothing reaches hi/lo.
    bus.op_valid = 1'b1;
    bus.md_op    = 3'd3;
    bus.rs_data  = 32'd100;
    bus.rt_data  = 32'd7;
    #1;
    chk("rstdiv.start", 32'(bus.start), 32'd1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rstdiv.busy_before", 32'(bus.busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstdiv.busy", 32'(bus.busy), 32'd0);
    chk("rstdiv.hi", bus.hi, 32'd0);
    chk("rstdiv.lo", bus.lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mhi = 32'd0;
    mlo = 32'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rstdiv.after_busy%0d", k), 32'(bus.busy), 32'd0);
    end
    chk("rstdiv.after_hi", bus.hi, 32'd0);
    chk("rstdiv.after_lo", bus.lo, 32'd0);
    do_op("post_rst", 1'b1, 3'd1, 32'd7, 32'd6, 1'b1, 5, 32'd0, 32'd42);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      v  = ($urandom_range(0, 7) != 0);
      rs = $urandom;
      rt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ((i % 10) == 3) begin
        rs = 32'h8000_0000;
        rt = 32'hFFFF_FFFF;
      end
      model(op, rs, rt, nh, nl, ar, cyc);
      if (!v) begin
        nh  = mhi;
        nl  = mlo;
        cyc = 0;
      end
      do_op($sformatf("rnd%0d", i), v, op, rs, rt, v & ar, (v & ar) ? cyc : 0, nh, nl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have parameter MULT_CYCLES, default 5, setting the busy cycles for MULT/MULTU.
REQ-002 The module SHALL have parameter DIV_CYCLES, default 10, setting the busy cycles for DIV/DIVU.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port op_valid, input, 1 bit: the E-stage instruction is valid and not stalled or flushed.
REQ-006 The module SHALL have port md_op, input, 3 bits: operation code from the shared encoding.
REQ-007 The module SHALL have port rs_data, input, 32 bits: forwarded operand A, which is the dividend or multiplicand.
REQ-008 The module SHALL have port rt_data, input, 32 bits: forwarded operand B, which is the divisor or multiplier.
REQ-009 The module SHALL have port start, output, 1 bit: combinational; high in a cycle where a MULT/MULTU/DIV/DIVU is presented and accepted.
REQ-010 The module SHALL have port busy, output, 1 bit: registered; high while an accepted operation is in flight.
REQ-011 The module SHALL have port hi, output, 32 bits: the architectural HI register.
REQ-012 The module SHALL have port lo, output, 32 bits: the architectural LO register.

Function
REQ-013 md_op SHALL be decoded as NONE, MULT, MULTU, DIV, DIVU, MTHI or MTLO; reserved codes SHALL be treated as NONE.
REQ-014 start SHALL equal op_valid & ~busy & (md_op in {MULT, MULTU, DIV, DIVU}).
REQ-015 When start is high in cycle T, the edge ending T SHALL capture the result into shadow registers and load the down-counter with MULT_CYCLES or DIV_CYCLES.
REQ-016 busy SHALL be high exactly when the counter is nonzero: cycles T+1..T+5 for multiply and T+1..T+10 for divide.
REQ-017 On the edge where the counter goes from 1 to 0, hi/lo SHALL load the shadow values; the new hi/lo SHALL be visible from cycle T+6 (multiply) or T+11 (divide), the same cycle busy is low.
REQ-018 MULT SHALL form the signed 64-bit product and MULTU the unsigned 64-bit product, with {hi, lo} = product.
REQ-019 DIV/DIVU SHALL set lo = quotient and hi = remainder.
REQ-020 The signed quotient SHALL truncate toward zero, and the signed remainder SHALL take the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000.
REQ-022 Division by zero SHALL still assert busy for DIV_CYCLES, and hi/lo SHALL remain unchanged at completion.
REQ-023 MTHI/MTLO with op_valid and ~busy SHALL write rs_data to hi/lo at the end of that cycle; start SHALL stay low.
REQ-024 Any md_op presented while busy SHALL be ignored: no start, no hi/lo write, counter unaffected.
REQ-025 The hazard unit stalls in this case; ignoring such ops is a defensive rule.
REQ-026 A start on the cycle immediately after busy falls SHALL be accepted normally (back-to-back operation).
REQ-027 op_valid low SHALL suppress all actions regardless of md_op.

Reset
REQ-028 reset_n low SHALL asynchronously clear hi, lo, the shadow registers and the counter to 0, forcing busy low.
REQ-029 reset_n low mid-operation SHALL abort the operation; the aborted result SHALL never reach hi/lo.
REQ-030 The first accepted op after reset_n deasserts SHALL behave as from idle.

Structure
REQ-031 The md_op encodings and the MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared instruction-type header alongside the other instruction encodings.
REQ-032 The cycle counter SHALL be the only state machine: IDLE when the count is 0, RUN otherwise; no further FSM is required.
REQ-033 Arithmetic SHALL be computed combinationally at acceptance; no iterative divider is required.
REQ-034 No sub-module is required; a small down-counter sub-module, md_counter, is permitted.

Verification
REQ-035 MULT with rs = 0xFFFFFFFE (-2) and rt = 3 SHALL give: start in T; busy in T+1..T+5; from T+6, hi = 0xFFFFFFFF and lo = 0xFFFFFFFA.
REQ-036 MULTU with rs = 0xFFFFFFFF and rt = 0xFFFFFFFF SHALL give hi = 0xFFFFFFFE and lo = 0x00000001 at T+6.
REQ-037 DIV with rs = -7 and rt = 2 SHALL keep busy for 10 cycles, then give lo = 0xFFFFFFFD (-3) and hi = 0xFFFFFFFF (-1) at T+11.
REQ-038 DIVU with rt = 0, after MTHI 0x1234 and MTLO 0x5678, SHALL assert busy for 10 cycles and leave hi = 0x1234 and lo = 0x5678.
REQ-039 MULT immediately followed by MTLO 0xAAAA while busy SHALL ignore the MTLO, and lo SHALL equal the product at T+6.
REQ-040 reset_n pulsed low during cycle T+3 of a DIV SHALL immediately drive busy low and hi = lo = 0, with no later update.
